fxp_divider: RTL and testbench

FXP_DIVIDER -- requirements
Module: fxp_divider

---
 rtl/fxp_divider_if.sv | 25 ++
 rtl/fxp_divider.sv | 136 +++++++++++++
 tb/tb_fxp_divider.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fxp_divider_if.sv
// Handshake and data bundle for the unsigned fixed-point divider.
// master drives the request side; slave is the divider itself.
interface fxp_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             div_by_zero;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, out, zero, div_by_zero, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, out, zero, div_by_zero, ovf
    );
endinterface

// File: rtl/fxp_divider.sv
// Sequential restoring divider for unsigned Q(WIDTH-FRAC).FRAC operands, one quotient bit per cycle.
// Optional saturation on quotient overflow is enabled by defining FXP_DIV_SATURATE_EN.
module fxp_divider #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 12
) (
    input  logic         clk,
    input  logic         rst,
    fxp_divider_if.slave bus
);
    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count, count_next;
    logic [N-1:0]     quot, quot_next;
    logic [WIDTH-1:0] divisor, divisor_next;
    logic [WIDTH-1:0] rem, rem_next;
    logic [WIDTH-1:0] out_q, out_next;
    logic             zero_q, zero_next;
    logic             dbz_q, dbz_next;
    logic             ovf_q, ovf_next;
    logic             done_q, done_next;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;

    // quot starts as the pre-shifted dividend; quotient bits enter at the LSB as dividend bits leave the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            quot    <= '0;
            divisor <= '0;
            rem     <= '0;
            out_q   <= '0;
            zero_q  <= 1'b1;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            quot    <= quot_next;
            divisor <= divisor_next;
            rem     <= rem_next;
            out_q   <= out_next;
            zero_q  <= zero_next;
            dbz_q   <= dbz_next;
            ovf_q   <= ovf_next;
            done_q  <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        count_next   = count;
        quot_next    = quot;
        divisor_next = divisor;
        rem_next     = rem;
        out_next     = out_q;
        zero_next    = zero_q;
        dbz_next     = dbz_q;
        ovf_next     = ovf_q;
        done_next    = 1'b0;
        rem_shift    = {rem, quot[N-1]};
        rem_sub      = rem_shift - {1'b0, divisor};

        case (state)
            IDLE: begin
                if (bus.start) begin
                    quot_next    = N'(bus.a) << FRAC;
                    divisor_next = bus.b;
                    rem_next     = '0;
                    dbz_next     = 1'b0;
                    ovf_next     = 1'b0;
                    count_next   = CW'(N);
                    state_next   = (bus.b == '0) ? DONE : RUN;
                end
            end

            RUN: begin
                // The partial remainder is always below the divisor, so rem_shift fits in WIDTH+1 bits
                if (rem_shift >= {1'b0, divisor}) begin
                    rem_next  = rem_sub[WIDTH-1:0];
                    quot_next = {quot[N-2:0], 1'b1};
                end else begin
                    rem_next  = rem_shift[WIDTH-1:0];
                    quot_next = {quot[N-2:0], 1'b0};
                end
                count_next = count - 1'b1;
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
                done_next  = 1'b1;
                if (divisor == '0) begin
                    out_next = '1;
                    dbz_next = 1'b1;
                end else begin
`ifdef FXP_DIV_SATURATE_EN
                    if (|quot[N-1:WIDTH]) begin
                        out_next = '1;
                        ovf_next = 1'b1;
                    end else begin
                        out_next = quot[WIDTH-1:0];
                    end
`else
                    out_next = quot[WIDTH-1:0];
`endif
                end
                zero_next = (out_next == '0);
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.out         = out_q;
    assign bus.zero        = zero_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_fxp_divider.sv
// Randomized scoreboard bench for fxp_divider against a plain-arithmetic reference model.
// Honours FXP_DIV_SATURATE_EN the same way as the design build.
module tb_fxp_divider;
    localparam int WIDTH = 32;
    localparam int FRAC  = 12;
    localparam int N     = WIDTH + FRAC;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             dbz;
        logic             ovf;
        int unsigned      due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    exp_t        sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fxp_divider_if #(.WIDTH(WIDTH)) bus ();

    fxp_divider #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t        e;
        logic [63:0] q;
        e.out = '0;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.due = 0;
        if (b == '0) begin
            e.out = '1;
            e.dbz = 1'b1;
        end else begin
            q = ({32'd0, a} << FRAC) / {32'd0, b};
`ifdef FXP_DIV_SATURATE_EN
            if ((q >> WIDTH) != 64'd0) begin
                e.out = '1;
                e.ovf = 1'b1;
            end else begin
                e.out = q[WIDTH-1:0];
            end
`else
            e.out = q[WIDTH-1:0];
`endif
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Issue one request from a negedge; tracked requests get their expected result queued
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit track);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        if (track) begin
            e     = model(a, b);
            e.due = cyc + 1 + ((b == '0) ? 1 : N + 1);
            sbq.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((sbq.size() != 0 || bus.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || bus.busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: got pending=%0d busy=%0b expected pending=0 busy=0", sbq.size(), bus.busy);
            sbq.delete();
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, WIDTH'(bus.busy), '0);
        checkOutput({tag, "_done"}, WIDTH'(bus.done), '0);
        checkOutput({tag, "_out"}, bus.out, '0);
        checkOutput({tag, "_zero"}, WIDTH'(bus.zero), WIDTH'(1));
        checkOutput({tag, "_dbz"}, WIDTH'(bus.div_by_zero), '0);
        checkOutput({tag, "_ovf"}, WIDTH'(bus.ovf), '0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
            end else begin
                e = sbq.pop_front();
                checkOutput("out", bus.out, e.out);
                checkOutput("zero", WIDTH'(bus.zero), WIDTH'(e.out == '0));
                checkOutput("div_by_zero", WIDTH'(bus.div_by_zero), WIDTH'(e.dbz));
                checkOutput("ovf", WIDTH'(bus.ovf), WIDTH'(e.ovf));
                checkOutput("latency", WIDTH'(cyc), WIDTH'(e.due));
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;

        applyStimulus(32'd847872, 32'd2048, 1'b1);
        checkOutput("busy_in_run", WIDTH'(bus.busy), WIDTH'(1));
        waitIdle(100);
        applyStimulus(32'd4096, 32'd16384, 1'b1);
        waitIdle(100);
        applyStimulus(32'd0, 32'd4096, 1'b1);
        waitIdle(100);
        applyStimulus(32'd12345, 32'd0, 1'b1);
        waitIdle(100);
        applyStimulus(32'hFFFFF000, 32'd1, 1'b1);
        waitIdle(100);

        // New operands offered mid-run must not disturb the running division
        applyStimulus(32'd300000, 32'd7000, 1'b1);
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd99;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        waitIdle(100);

        // A start sampled in the DONE cycle must be dropped
        applyStimulus(32'd5000000, 32'd12288, 1'b1);
        repeat (N) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd7;
        bus.b     = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("busy_after_done_start", WIDTH'(bus.busy), '0);
        waitIdle(100);
        repeat (5) @(negedge clk);

        // Reset mid-run aborts with no done pulse, then a fresh request completes
        applyStimulus(32'd777777, 32'd333, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetOutputs("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        applyStimulus(32'd40960, 32'd8192, 1'b1);
        waitIdle(100);

        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = rb >> $urandom_range(8, 31);
                1: rb = rb >> $urandom_range(24, 31);
                2: ra = ra >> $urandom_range(4, 28);
                3: rb = '0;
                default: ;
            endcase
            applyStimulus(ra, rb, 1'b1);
            waitIdle(100);
        end

        checkOutput("scoreboard_empty", WIDTH'(sbq.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
